// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the sequencer state encoding and the load-use detection helper.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    MEM_WAIT  = 2'd1,
    IRQ_ENTRY = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO  = 5'd0;
  localparam int         CNT_W_DEF = 16;

  // Register $zero never carries a real dependency, so a load into it is not a hazard.
  function automatic logic load_use(input logic       ex_mem_read,
                                    input logic [4:0] ex_rt,
                                    input logic [4:0] id_rs,
                                    input logic [4:0] id_rt,
                                    input logic       id_uses_rs,
                                    input logic       id_uses_rt);
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((id_uses_rs && (ex_rt == id_rs)) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous reset and clear.
// A clear wins over an increment; the count sticks at all-ones.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // NOTE: sequential state is written with non-blocking assignments only, so
  // every flop samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      count_q <= '0;
    end else if (inc && (count_q != '1)) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline sequencer: decides hold/flush of PC, IF/ID and ID/EX
// each cycle from load-use, branch/jump, slow-memory and interrupt inputs.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             mem_req,
  input  logic             irq_req,
  input  logic             cnt_clr,
  output logic             hold_PC,
  output logic             hold_IFID,
  output logic             hold_IDEX,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             pc_sel_irq,
  output logic             irq_ack,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam bit          FREEZE_EN = (MEM_WAIT_CYCLES > 0);
  localparam int          WAIT_W    = FREEZE_EN ? $clog2(MEM_WAIT_CYCLES + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = FREEZE_EN ? WAIT_W'(MEM_WAIT_CYCLES - 1) : '0;

  state_e            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              lu;

  assign lu = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rs, id_uses_rt);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    hold_PC    = 1'b0;
    hold_IFID  = 1'b0;
    hold_IDEX  = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    pc_sel_irq = 1'b0;
    irq_ack    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        RUN: begin
          if (mem_req && FREEZE_EN) begin
            {hold_PC, hold_IFID, hold_IDEX} = 3'b111;
            wait_d = WAIT_LOAD;
            if (WAIT_LOAD != '0) state_d = MEM_WAIT;
          end else if (branch_taken_ex) begin
            {flush_IFID, flush_IDEX} = 2'b11;
          end else if (lu) begin
            {hold_PC, hold_IFID, flush_IDEX} = 3'b111;
          end else if (jump_id) begin
            flush_IFID = 1'b1;
          end else if (irq_req) begin
            // Taken only in an otherwise quiet cycle so the saved PC is precise.
            state_d = IRQ_ENTRY;
          end
        end
        MEM_WAIT: begin
          {hold_PC, hold_IFID, hold_IDEX} = 3'b111;
          // The last frozen cycle is the one whose count drops to zero.
          if (wait_q <= WAIT_W'(1)) begin
            wait_d  = '0;
            state_d = RUN;
          end else begin
            wait_d = wait_q - WAIT_W'(1);
          end
        end
        IRQ_ENTRY: begin
          {flush_IFID, flush_IDEX, pc_sel_irq, irq_ack} = 4'b1111;
          state_d = RUN;
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (hold_PC),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (flush_IFID),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: single-cycle rule table plus hand-written
// sequences for memory freeze, deferred interrupt, counters and reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rs, id_uses_rt, ex_mem_read;
  logic        branch_taken_ex, jump_id, mem_req, irq_req, cnt_clr;

  logic        hold_PC, hold_IFID, hold_IDEX, flush_IFID, flush_IDEX, pc_sel_irq, irq_ack;
  logic [15:0] stall_cnt, flush_cnt;

  logic        h1_pc, h1_ifid, h1_idex, f1_ifid, f1_idex, p1_irq, a1_irq;
  logic [3:0]  s1_cnt, f1_cnt;

  logic [6:0]  outs, outs1;
  assign outs  = {hold_PC, hold_IFID, hold_IDEX, flush_IFID, flush_IDEX, pc_sel_irq, irq_ack};
  assign outs1 = {h1_pc, h1_ifid, h1_idex, f1_ifid, f1_idex, p1_irq, a1_irq};

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_WAIT_CYCLES(3), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .mem_req(mem_req),
    .irq_req(irq_req), .cnt_clr(cnt_clr),
    .hold_PC(hold_PC), .hold_IFID(hold_IFID), .hold_IDEX(hold_IDEX),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .pc_sel_irq(pc_sel_irq), .irq_ack(irq_ack),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Second instance: single-cycle freeze and a narrow counter.
  hazard_ctrl #(.MEM_WAIT_CYCLES(1), .CNT_W(4)) dut1 (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .branch_taken_ex(branch_taken_ex), .jump_id(jump_id), .mem_req(mem_req),
    .irq_req(irq_req), .cnt_clr(cnt_clr),
    .hold_PC(h1_pc), .hold_IFID(h1_ifid), .hold_IDEX(h1_idex),
    .flush_IFID(f1_ifid), .flush_IDEX(f1_idex),
    .pc_sel_irq(p1_irq), .irq_ack(a1_irq),
    .stall_cnt(s1_cnt), .flush_cnt(f1_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
    branch_taken_ex = 1'b0; jump_id = 1'b0; mem_req = 1'b0;
    irq_req = 1'b0; cnt_clr = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected outputs: {hold_PC, hold_IFID, hold_IDEX, flush_IFID, flush_IDEX, pc_sel_irq, irq_ack}
  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] ex_rt;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       br;
    logic       jmp;
    logic [6:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{"lu_rs",        1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 7'b1100100};
    vecs[1] = '{"lu_rt_zero",   1'b1, 5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[2] = '{"lu_rt",        1'b1, 5'd12, 5'd3,  5'd12, 1'b0, 1'b1, 1'b0, 1'b0, 7'b1100100};
    vecs[3] = '{"rs_not_used",  1'b1, 5'd8,  5'd8,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};
    vecs[4] = '{"not_load",     1'b0, 5'd8,  5'd8,  5'd8,  1'b1, 1'b1, 1'b0, 1'b0, 7'b0000000};
    vecs[5] = '{"branch_ov_lu", 1'b1, 5'd8,  5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 7'b0001100};
    vecs[6] = '{"jump",         1'b0, 5'd0,  5'd1,  5'd2,  1'b1, 1'b1, 1'b0, 1'b1, 7'b0001000};
    vecs[7] = '{"lu_ov_jump",   1'b1, 5'd31, 5'd4,  5'd31, 1'b1, 1'b1, 1'b0, 1'b1, 7'b1100100};
    vecs[8] = '{"branch",       1'b0, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 7'b0001100};
    vecs[9] = '{"quiet",        1'b0, 5'd5,  5'd5,  5'd6,  1'b0, 1'b0, 1'b0, 1'b0, 7'b0000000};

    idle();
    reset = 1'b1;
    tick();
    tick();
    // Reset gates every control output even with active requests.
    jump_id = 1'b1; mem_req = 1'b1; branch_taken_ex = 1'b1;
    #3 check("reset_outs", 32'(outs), 32'd0);
    tick();
    reset = 1'b0;
    idle();
    #3 check("post_reset_outs", 32'(outs), 32'd0);
    check("post_reset_stall", 32'(stall_cnt), 32'd0);
    check("post_reset_flush", 32'(flush_cnt), 32'd0);
    tick();

    // Single-cycle rule table in RUN.
    for (int i = 0; i < 10; i++) begin
      ex_mem_read = vecs[i].mr; ex_rt = vecs[i].ex_rt;
      id_rs = vecs[i].rs; id_rt = vecs[i].rt;
      id_uses_rs = vecs[i].urs; id_uses_rt = vecs[i].urt;
      branch_taken_ex = vecs[i].br; jump_id = vecs[i].jmp;
      #3 check(vecs[i].name, 32'(outs), 32'(vecs[i].exp));
      tick();
      exp_stall += int'(vecs[i].exp[6]);
      exp_flush += int'(vecs[i].exp[3]);
      check({vecs[i].name, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
      check({vecs[i].name, "_flush_cnt"}, 32'(flush_cnt), 32'(exp_flush));
    end
    idle();

    // Memory freeze, three cycles; a branch inside the freeze is ignored.
    mem_req = 1'b1;
    #3 check("freeze_c0", 32'(outs), 32'b1110000);
    check("freeze1_c0", 32'(outs1), 32'b1110000);
    tick();
    mem_req = 1'b0; branch_taken_ex = 1'b1;
    #3 check("freeze_c1_br_ignored", 32'(outs), 32'b1110000);
    check("freeze1_c1_branch", 32'(outs1), 32'b0001100);
    tick();
    branch_taken_ex = 1'b0;
    #3 check("freeze_c2", 32'(outs), 32'b1110000);
    tick();
    #3 check("freeze_c3_release", 32'(outs), 32'd0);
    tick();
    exp_stall += 3;
    check("freeze_stall_cnt", 32'(stall_cnt), 32'(exp_stall));
    check("freeze_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // Interrupt deferred by a jump, then taken.
    irq_req = 1'b1; jump_id = 1'b1;
    #3 check("irq_defer_jump", 32'(outs), 32'b0001000);
    tick();
    jump_id = 1'b0;
    #3 check("irq_accept", 32'(outs), 32'd0);
    tick();
    #3 check("irq_entry", 32'(outs), 32'b0001111);
    tick();
    irq_req = 1'b0;
    #3 check("irq_back_run", 32'(outs), 32'd0);
    tick();
    exp_flush += 2;
    check("irq_flush_cnt", 32'(flush_cnt), 32'(exp_flush));

    // Reset during the freeze aborts it.
    mem_req = 1'b1;
    tick();
    mem_req = 1'b0; reset = 1'b1;
    #3 check("reset_mid_freeze_outs", 32'(outs), 32'd0);
    tick();
    reset = 1'b0;
    #3 check("after_reset_run", 32'(outs), 32'd0);
    check("after_reset_stall", 32'(stall_cnt), 32'd0);
    check("after_reset_flush", 32'(flush_cnt), 32'd0);
    jump_id = 1'b1;
    #1 check("after_reset_jump", 32'(outs), 32'b0001000);
    tick();
    jump_id = 1'b0;

    // Counter clear, saturation, and clear over increment.
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    check("clr_flush", 32'(flush_cnt), 32'd0);
    jump_id = 1'b1;
    repeat (16'hFFFE) tick();
    check("preload_flush", 32'(flush_cnt), 32'h0000FFFE);
    check("narrow_sat_flush", 32'(f1_cnt), 32'h0000000F);
    repeat (3) tick();
    check("sat_flush", 32'(flush_cnt), 32'h0000FFFF);
    check("sat_stall_untouched", 32'(stall_cnt), 32'd0);
    cnt_clr = 1'b1;
    #3 check("clr_with_flush_outs", 32'(outs), 32'b0001000);
    tick();
    check("clr_over_inc", 32'(flush_cnt), 32'd0);
    check("clr_over_inc_narrow", 32'(f1_cnt), 32'd0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
